subleq_sequencer: RTL and testbench
===================================

// Module: subleq_sequencer
// PURPOSE
// - Instruction sequencer/execute FSM for the SUBLEQ core, downstream of data_in_buffer.
// - Drives the sync-read memory's address, write data and write enable.
// - Consumes the three read-data taps (current, -1 cycle, -2 cycle) to grab operands A,B,C in one cycle.
// - Executes mem[B] <= mem[B] - mem[A]; if result <= 0 then pc <= C, else pc <= pc + 3.
// PARAMETERS
// - RESET_PC   0             pc loaded on reset; width `WORD_SIZE
// - HALT_PC    {W{1'b1}}     a branch target equal to this value halts the core
// - W = `WORD_SIZE from defines.vh; not a module parameter
// PORTS
// - clk        in   1  clock
// - areset     in   1  reset: synchronous, active-high
// - run        in   1  permit starting a new instruction
// - data_in_0  in   W  memory read data for address issued last cycle
// - data_in_1  in   W  data_in_0 delayed 1 clk (from data_in_buffer)
// - data_in_2  in   W  data_in_0 delayed 2 clk (from data_in_buffer)
// - mem_addr   out  W  memory address (read every cycle; write when mem_we)
// - mem_wdata  out  W  write data
// - mem_we     out  1  write enable; memory writes at posedge
// - pc         out  W  current program counter (registered)
// - instr_done out  1  1-cycle pulse in EXEC state
// - halted     out  1  high while in HALT
// BEHAVIOUR
// - Memory contract: 1-cycle sync read; addr in cycle n -> data_in_0 in cycle n+1. Buffer taps shift every clk with no stall.
// - States / mem_addr per state:
//   - FETCH_A: addr = pc
//   - FETCH_B: addr = pc+1
//   - FETCH_C: addr = pc+2
//   - READ_A: addr = data_in_2 (= A). In this cycle, register a_r <= data_in_2, b_r <= data_in_1, c_r <= data_in_0.
//   - READ_B: addr = b_r
//   - EXEC: addr = b_r; we = 1; wdata = data_in_0 - data_in_1 (mem[B] - mem[A]).
//   - HALT: addr = pc; we = 0
// - Transitions:
//   - FETCH_A -> FETCH_B only if run=1; otherwise hold in FETCH_A. Holding re-reads pc and is harmless.
//   - FETCH_B -> FETCH_C -> READ_A -> READ_B -> EXEC: unconditional; run is ignored mid-instruction.
//   - EXEC -> HALT if next pc == HALT_PC; otherwise EXEC -> FETCH_A.
//   - HALT is exited only by areset.
// - Throughput: 6 clk per instruction with run held high.
// - Arithmetic:
//   - Subtraction is modulo 2^W.
//   - leq = (diff == 0) | diff[W-1] (two's-complement signed compare).
//   - pc+1, pc+2, pc+3 wrap modulo 2^W; e.g. pc = 2^W-2 fetches 2^W-2, 2^W-1, 0.
// - pc update: registered at the EXEC edge, to C if leq else pc+3.
// - The EXEC write always occurs, including on the halting instruction.
// - Self-modifying code: the EXEC write lands at its edge, so the following FETCH_A read returns the new value.
// - Reset (areset=1 at posedge):
//   - state <= FETCH_A, pc <= RESET_PC; a_r, b_r, c_r <= 0.
//   - mem_we, mem_wdata, instr_done, halted are all 0 after the edge.
//   - mem_we and instr_done are gated by !areset combinationally: reset asserted during EXEC suppresses that write.
//   - Mid-instruction reset aborts the instruction; pc does not update.
// - HALT_PC == pc+3 on a non-branch (fall-through) also halts.
// - No X on outputs after the first reset edge.
// STRUCTURE
// - defines.vh: `WORD_SIZE and state-encoding `defines (3-bit, binary).
// - One natural sub-module, subleq_alu (combinational): inputs a_val, b_val; outputs diff, leq.
// - Everything else is the FSM plus the pc/a_r/b_r/c_r registers.
// TESTING (W=16)
// Bench: sync RAM model + data_in_buffer + this block.
// - Reset: areset high 2 clk -> mem_addr=0, mem_we=0, pc=0, halted=0; run=0 keeps state in FETCH_A indefinitely.
// - Fall-through: mem[0..2]={6,7,20}, mem[6]=2, mem[7]=5, run=1 -> clk 6 mem_we=1, addr=7, wdata=3, instr_done=1; then pc=3.
// - Branch on zero: mem[6]=5, mem[7]=5 -> wdata=0, pc=20; next FETCH_A addr=20.
// - Branch on negative: mem[6]=1, mem[7]=0 -> wdata=16'hFFFF, pc=20; pc wrap: start at 16'hFFFE fetches FFFE, FFFF, 0000.
// - Halt: C=16'hFFFF, taken branch -> write performed, halted=1 next clk; mem_we stays 0 for 20 clk.
// - Reset during EXEC: mem_we=0 in that cycle, target word unchanged, pc=RESET_PC after edge.

Source files
------------

// File: rtl/subleq_sequencer_pkg.sv
// subleq_sequencer_pkg: word width and FSM state encoding shared by the SUBLEQ sequencer files.
package subleq_sequencer_pkg;
  localparam int W = 16;
  typedef enum logic [2:0] {
    FETCH_A = 3'd0,
    FETCH_B = 3'd1,
    FETCH_C = 3'd2,
    READ_A  = 3'd3,
    READ_B  = 3'd4,
    EXEC    = 3'd5,
    HALT    = 3'd6
  } state_t;
endpackage

// File: rtl/subleq_alu.sv
// subleq_alu: mem[B] - mem[A] modulo 2^W and the signed less-or-equal-zero branch condition.
module subleq_alu
  import subleq_sequencer_pkg::*;
(
  input  logic [W-1:0] a_val,
  input  logic [W-1:0] b_val,
  output logic [W-1:0] diff,
  output logic         leq
);
  assign diff = b_val - a_val;
  assign leq  = (diff == '0) || diff[W-1];
endmodule

// File: rtl/subleq_sequencer.sv
// subleq_sequencer: six-cycle fetch/read/execute FSM driving a 1-cycle sync-read memory.
module subleq_sequencer
  import subleq_sequencer_pkg::*;
#(
  parameter logic [W-1:0] RESET_PC = '0,
  parameter logic [W-1:0] HALT_PC  = '1
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         run,
  input  logic [W-1:0] data_in_0,
  input  logic [W-1:0] data_in_1,
  input  logic [W-1:0] data_in_2,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  output logic         mem_we,
  output logic [W-1:0] pc,
  output logic         instr_done,
  output logic         halted
);
  state_t state;
  logic [W-1:0] b_r, c_r, diff, next_pc;
  logic leq, exec;
  subleq_alu u_alu (
    .a_val(data_in_1),
    .b_val(data_in_0),
    .diff (diff),
    .leq  (leq)
  );
  assign exec    = state == EXEC;
  assign next_pc = leq ? c_r : pc + W'(3);
  // READ_A addresses A straight from the oldest tap; A itself needs no register
  assign mem_addr = state == FETCH_B ? pc + W'(1) :
                    state == FETCH_C ? pc + W'(2) :
                    state == READ_A  ? data_in_2  :
                    (state == READ_B || exec) ? b_r : pc;
  assign mem_we     = exec && !areset;
  assign mem_wdata  = exec ? diff : '0;
  assign instr_done = mem_we;
  assign halted     = state == HALT;
  always_ff @(posedge clk) begin
    if (areset) begin
      state <= FETCH_A;
      pc    <= RESET_PC;
      b_r   <= '0;
      c_r   <= '0;
    end else begin
      case (state)
        FETCH_A: state <= run ? FETCH_B : FETCH_A;
        FETCH_B: state <= FETCH_C;
        FETCH_C: state <= READ_A;
        READ_A: begin
          state <= READ_B;
          b_r   <= data_in_1;
          c_r   <= data_in_0;
        end
        READ_B: state <= EXEC;
        EXEC: begin
          pc    <= next_pc;
          state <= next_pc == HALT_PC ? HALT : FETCH_A;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_subleq_sequencer.sv
// tb_subleq_sequencer: sync RAM + tap buffer around the sequencer, instruction-level model and directed programs.
module tb_subleq_sequencer;
  logic clk = 1'b0;
  logic areset, run;
  logic [15:0] d0, d1, d2, mem_addr, mem_wdata, pc;
  logic mem_we, instr_done, halted;
  logic [15:0] ram [0:65535];
  logic [15:0] mmem [0:65535];
  int checks = 0, errors = 0;
  bit live = 1'b0;
  int ph = 0;
  bit m_halt = 1'b0;
  logic [15:0] m_pc = '0, m_b, m_diff, m_npc, ma, mb, mc;
  logic [15:0] ea [0:5];
  subleq_sequencer dut (
    .clk       (clk),
    .areset    (areset),
    .run       (run),
    .data_in_0 (d0),
    .data_in_1 (d1),
    .data_in_2 (d2),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .pc        (pc),
    .instr_done(instr_done),
    .halted    (halted)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    d0 <= ram[mem_addr];
    d1 <= d0;
    d2 <= d1;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: whole instruction computed at start from the model memory, then replayed as a 6-cycle address schedule
  always @(negedge clk) if (live) begin
    if (areset) begin
      chk("rst_we", {31'b0, mem_we}, 0);
      chk("rst_done", {31'b0, instr_done}, 0);
      ph = 0;
      m_pc = '0;
      m_halt = 1'b0;
    end else if (m_halt) begin
      chk("halt_addr", {16'b0, mem_addr}, {16'b0, m_pc});
      chk("halt_we", {31'b0, mem_we}, 0);
      chk("halt_flag", {31'b0, halted}, 1);
      chk("halt_pc", {16'b0, pc}, {16'b0, m_pc});
    end else begin
      if (ph == 0) begin
        ma = mmem[m_pc];
        mb = mmem[16'(m_pc + 16'd1)];
        mc = mmem[16'(m_pc + 16'd2)];
        ea[0] = m_pc;
        ea[1] = m_pc + 16'd1;
        ea[2] = m_pc + 16'd2;
        ea[3] = ma;
        ea[4] = mb;
        ea[5] = mb;
        m_b = mb;
        m_diff = mmem[mb] - mmem[ma];
        m_npc = (m_diff == 0 || $signed(m_diff) < 0) ? mc : m_pc + 16'd3;
      end
      chk("addr", {16'b0, mem_addr}, {16'b0, ea[ph]});
      chk("we", {31'b0, mem_we}, {31'b0, ph == 5});
      chk("done", {31'b0, instr_done}, {31'b0, ph == 5});
      chk("halted", {31'b0, halted}, 0);
      chk("pc", {16'b0, pc}, {16'b0, m_pc});
      if (ph == 5) begin
        chk("wdata", {16'b0, mem_wdata}, {16'b0, m_diff});
        mmem[m_b] = m_diff;
        m_pc = m_npc;
        m_halt = m_npc == 16'hFFFF;
        ph = 0;
      end else if (ph != 0 || run) ph++;
    end
  end
  task automatic load(input logic [15:0] a, input logic [15:0] v);
    ram[a] <= v;
    mmem[a] = v;
  endtask
  task automatic boot();
    areset = 1'b1;
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
  endtask
  task automatic wait_done(input string name, input int exp_n);
    int n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (instr_done) begin
        n = i;
        break;
      end
    end
    chk(name, n, exp_n);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int wes;
    int n;
    areset = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      ram[i] <= '0;
      mmem[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 live = 1'b1;
    areset = 1'b0;
    #1;
    chk("reset_addr", {16'b0, mem_addr}, 0);
    chk("reset_we", {31'b0, mem_we}, 0);
    chk("reset_pc", {16'b0, pc}, 0);
    chk("reset_halted", {31'b0, halted}, 0);
    repeat (5) step();
    chk("idle_addr", {16'b0, mem_addr}, 0);
    chk("idle_pc", {16'b0, pc}, 0);
    // fall-through: 5 - 2 = 3 > 0
    load(0, 6); load(1, 7); load(2, 20); load(6, 2); load(7, 5);
    boot();
    run = 1'b1;
    wait_done("ft_latency", 5);
    run = 1'b0;
    chk("ft_addr", {16'b0, mem_addr}, 7);
    chk("ft_wdata", {16'b0, mem_wdata}, 3);
    chk("ft_we", {31'b0, mem_we}, 1);
    step();
    chk("ft_pc", {16'b0, pc}, 3);
    chk("ft_ram", {16'b0, ram[7]}, 3);
    // branch on zero
    load(6, 5); load(7, 5);
    boot();
    run = 1'b1;
    wait_done("bz_latency", 5);
    run = 1'b0;
    chk("bz_wdata", {16'b0, mem_wdata}, 0);
    step();
    chk("bz_pc", {16'b0, pc}, 20);
    chk("bz_addr", {16'b0, mem_addr}, 20);
    // branch on negative
    load(6, 1); load(7, 0);
    boot();
    run = 1'b1;
    wait_done("bn_latency", 5);
    run = 1'b0;
    chk("bn_wdata", {16'b0, mem_wdata}, 16'hFFFF);
    step();
    chk("bn_pc", {16'b0, pc}, 20);
    // pc wrap: jump to FFFE, then fetch FFFE, FFFF, 0000
    load(0, 8); load(1, 9); load(2, 16'hFFFE); load(8, 0); load(9, 0);
    load(16'hFFFE, 6); load(16'hFFFF, 7); load(6, 1); load(7, 5);
    boot();
    run = 1'b1;
    wait_done("wr_latency", 5);
    step();
    chk("wr_fa", {16'b0, mem_addr}, 16'hFFFE);
    step();
    chk("wr_fb", {16'b0, mem_addr}, 16'hFFFF);
    step();
    chk("wr_fc", {16'b0, mem_addr}, 16'h0000);
    wait_done("wr_latency2", 3);
    run = 1'b0;
    chk("wr_wdata", {16'b0, mem_wdata}, 4);
    step();
    chk("wr_pc", {16'b0, pc}, 1);
    // halt: branch to FFFF, write still lands
    load(0, 6); load(1, 7); load(2, 16'hFFFF); load(6, 5); load(7, 5);
    boot();
    run = 1'b1;
    wait_done("h_latency", 5);
    chk("h_we", {31'b0, mem_we}, 1);
    chk("h_not_yet", {31'b0, halted}, 0);
    wes = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_we) wes++;
    end
    chk("h_we_count", wes, 0);
    chk("h_halted", {31'b0, halted}, 1);
    chk("h_pc", {16'b0, pc}, 16'hFFFF);
    chk("h_ram", {16'b0, ram[7]}, 0);
    // reset during EXEC suppresses the write
    load(2, 20); load(6, 2); load(7, 5);
    boot();
    run = 1'b1;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (mem_we) begin
        n = i;
        break;
      end
    end
    chk("re_reach_exec", n, 5);
    areset = 1'b1;
    #1;
    chk("re_we", {31'b0, mem_we}, 0);
    chk("re_done", {31'b0, instr_done}, 0);
    step();
    areset = 1'b0;
    run = 1'b0;
    chk("re_pc", {16'b0, pc}, 0);
    step();
    chk("re_ram", {16'b0, ram[7]}, 5);
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
